pll_lock_detect: RTL and testbench
==================================

// Module: pll_lock_detect
// PURPOSE
//  Frequency lock detector downstream of pll: counts feedback-toggle events (fb_tgl flips once per
//  2**DIV_LOG2 pclk cycles, generated in the pclk domain) over a window of 2**WIN_LOG2 refclk cycles.
//  Compares the count with the expected N<<(WIN_LOG2-DIV_LOG2) and declares lock after LOCK_WINDOWS
//  consecutive in-tolerance windows. Feeds lock status to the PLL controller and the test bench.
// PARAMETERS
//  WIN_LOG2      12  log2 of measurement window length in refclk cycles
//  DIV_LOG2      10  log2 of pclk cycles per fb_tgl transition; DIV_LOG2 >= 2 + NW (toggle every >=4 refclk)
//  NW             8  width of n_div (PLL multiplication ratio)
//  TOL            2  allowed |count - expected| for a good window
//  LOCK_WINDOWS   4  consecutive good windows required to assert locked (>=1)
// PORTS
//  refclk        in   1          reference clock; sole clock
//  reset         in   1          synchronous, active-high reset
//  n_div         in   NW         PLL ratio N; static during lock, change restarts acquisition
//  fb_tgl        in   1          asynchronous toggle from pclk domain
//  clr_lost      in   1          single-cycle pulse clearing sticky lock_lost
//  locked        out  1          frequency lock indication
//  lock_lost     out  1          sticky: set when locked drops due to a bad window
//  meas_count    out  CW         last completed window count; CW = NW+WIN_LOG2-DIV_LOG2+1
//  meas_valid    out  1          one-cycle pulse when meas_count updates
// BEHAVIOUR
//  - Reset: locked=0, lock_lost=0, meas_count=0, meas_valid=0, state=DISCARD, counters=0, sync flops=0.
//  - fb_tgl passes a 2-flop synchronizer then an edge-detect flop; each change of the synced value = 1
//    event. Event-to-count latency 3 refclk cycles (constant, does not bias window counts).
//  - Window counter runs 0..2**WIN_LOG2-1, wraps; in the wrap cycle the event counter is latched into
//    meas_count, meas_valid pulses next cycle, event counter restarts at 0 (or 1 if an event lands in
//    the wrap cycle -- that event belongs to the new window, never lost or double-counted).
//  - Event counter saturates at all-ones (no wrap); saturated count is always a bad window.
//  - expected = n_div << (WIN_LOG2-DIV_LOG2), computed in CW bits; good = |count-expected| <= TOL,
//    signed difference computed in CW+1 bits.
//  - States:
//    DISCARD : first window after reset/n_div change; result ignored, meas_valid still pulses -> ACQUIRE.
//    ACQUIRE : good window increments good_cnt; bad clears it. good_cnt==LOCK_WINDOWS -> LOCKED,
//              locked=1 in the same cycle meas_valid pulses.
//    LOCKED  : good window stays; bad window -> ACQUIRE, locked=0, good_cnt=0, lock_lost=1.
//  - n_div change (compared to registered copy each cycle): any state -> DISCARD, window and event
//    counters reset, locked=0; lock_lost NOT set (intentional change).
//  - clr_lost clears lock_lost; if a loss occurs in the same cycle, set wins.
//  - reset mid-window: everything returns to reset values next edge; partial window discarded.
//  - n_div=0: expected=0; window good only if count<=TOL.
// STRUCTURE
//  - pll_pkg: lock_state_e enum {DISCARD, ACQUIRE, LOCKED}; localparam function for CW.
//  - Sub-module pll_sync2: generic 2-flop synchronizer (refclk, reset, d, q), reused elsewhere.
//  - Top: window counter, event counter, comparator, FSM, status registers.
// TESTING (defaults, N=32: expected=128, fb_tgl every 32 refclk)
//  1 reset 10 cycles, n_div=32, ideal toggles -> meas_valid every 4096 cycles, meas_count=128;
//    locked rises at end of window 5 (1 discard + 4 good), lock_lost stays 0.
//  2 locked, then toggle period 31 refclk (~132 events) -> locked falls at next window end,
//    lock_lost=1; restore period 32 -> relock after 4 windows; clr_lost pulse -> lock_lost=0.
//  3 counts 126 and 130 -> good (TOL=2); 125 and 131 -> bad, good_cnt resets, no lock.
//  4 locked, change n_div 32->40 -> locked=0 next cycle, lock_lost=0, window restarts; with toggle
//    period 25.6 avg (160 events) relocks after 5 windows.
//  5 fb_tgl event exactly in window-wrap cycle -> counted in new window, totals across 10 windows
//    equal total toggles; assert reset mid-window -> all outputs 0 next edge.
//  6 fb_tgl stuck -> meas_count=0, never locks; clr_lost coincident with loss -> lock_lost=1.

Source files
------------

// File: rtl/pll_lock_detect_pkg.sv
// Shared types and sizing helpers for the PLL frequency lock detector.
package pll_lock_detect_pkg;

  typedef enum logic [1:0] {
    DISCARD = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  // Width of a window event count: enough for N<<(WIN_LOG2-DIV_LOG2) plus headroom
  function automatic int calc_cw(input int nw, input int win_log2, input int div_log2);
    return nw + win_log2 - div_log2 + 1;
  endfunction

endpackage

// File: rtl/pll_lock_detect_if.sv
// Control/status bundle between the lock detector and its user (PLL controller or bench).
interface pll_lock_detect_if #(
  parameter int NW = 8,
  parameter int CW = 11
) ();

  logic [NW-1:0] n_div;
  logic          fb_tgl;
  logic          clr_lost;
  logic          locked;
  logic          lock_lost;
  logic [CW-1:0] meas_count;
  logic          meas_valid;

  modport master (
    output n_div, fb_tgl, clr_lost,
    input  locked, lock_lost, meas_count, meas_valid
  );

  modport slave (
    input  n_div, fb_tgl, clr_lost,
    output locked, lock_lost, meas_count, meas_valid
  );

endinterface

// File: rtl/pll_lock_detect_sync2.sv
// Generic two-flop synchronizer bringing an asynchronous level into the refclk domain.
module pll_lock_detect_sync2 (
  input  logic refclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first flop may go metastable, the second settles it
  always_ff @(posedge refclk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_detect.sv
// Frequency lock detector: counts feedback toggle events over a fixed refclk window,
// compares against N<<(WIN_LOG2-DIV_LOG2) and declares lock after enough good windows.
module pll_lock_detect
  import pll_lock_detect_pkg::*;
#(
  parameter int WIN_LOG2     = 12,
  parameter int DIV_LOG2     = 10,
  parameter int NW           = 8,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             refclk,
  input  logic             reset,
  pll_lock_detect_if.slave lk_if
);

  localparam int CW    = calc_cw(NW, WIN_LOG2, DIV_LOG2);
  localparam int SHIFT = WIN_LOG2 - DIV_LOG2;
  localparam int GW    = $clog2(LOCK_WINDOWS + 1);

  // Saturating increment: an all-ones count stays put and marks the window bad
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // |cnt - exp| <= TOL using a signed difference one bit wider than the count
  function automatic logic in_tol(input logic [CW-1:0] cnt, input logic [CW-1:0] exp_c);
    logic signed [CW:0] diff;
    logic signed [CW:0] tol_s;
    diff  = $signed({1'b0, cnt}) - $signed({1'b0, exp_c});
    tol_s = $signed((CW+1)'(TOL));
    return (diff <= tol_s) && (diff >= -tol_s);
  endfunction

  logic                fb_sync;
  logic                fb_prev_q;
  logic                fb_event;
  logic [NW-1:0]       ndiv_q;
  logic                ndiv_chg;
  logic [WIN_LOG2-1:0] win_q;
  logic [WIN_LOG2-1:0] win_d;
  logic                win_wrap;
  logic [CW-1:0]       ev_cnt_q;
  logic [CW-1:0]       ev_cnt_d;
  logic [CW-1:0]       expected_w;
  logic                win_good;
  logic [CW-1:0]       meas_count_q;
  logic                meas_valid_q;
  lock_state_e         state_q;
  lock_state_e         state_d;
  logic [GW-1:0]       good_cnt_q;
  logic [GW-1:0]       good_cnt_d;
  logic                loss;
  logic                lock_lost_q;
  logic                lock_lost_d;

  pll_lock_detect_sync2 u_sync (
    .refclk (refclk),
    .reset  (reset),
    .d      (lk_if.fb_tgl),
    .q      (fb_sync)
  );

  // Edge detect on the synchronized toggle: every level change is one event
  always_ff @(posedge refclk) begin
    if (reset) fb_prev_q <= 1'b0;
    else       fb_prev_q <= fb_sync;
  end

  assign fb_event = fb_sync ^ fb_prev_q;

  // Registered copy of the ratio; loaded every cycle so reset never fakes a change
  always_ff @(posedge refclk) begin
    ndiv_q <= lk_if.n_div;
  end

  assign ndiv_chg   = (lk_if.n_div != ndiv_q);
  assign win_wrap   = &win_q;
  assign expected_w = CW'(ndiv_q) << SHIFT;
  assign win_good   = !(&ev_cnt_q) && in_tol(ev_cnt_q, expected_w);

  // Window and event counter next state; an event in the wrap cycle opens the new window
  always_comb begin
    win_d    = win_q + WIN_LOG2'(1);
    ev_cnt_d = ev_cnt_q;
    if (ndiv_chg) begin
      win_d    = '0;
      ev_cnt_d = '0;
    end else if (win_wrap) begin
      ev_cnt_d = fb_event ? CW'(1) : '0;
    end else if (fb_event) begin
      ev_cnt_d = sat_inc(ev_cnt_q);
    end
  end

  // Counter and measurement registers
  always_ff @(posedge refclk) begin
    if (reset) begin
      win_q        <= '0;
      ev_cnt_q     <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      ev_cnt_q     <= ev_cnt_d;
      meas_valid_q <= win_wrap && !ndiv_chg;
      if (win_wrap && !ndiv_chg) meas_count_q <= ev_cnt_q;
    end
  end

  // Lock FSM next state; evaluated only at window close or on a ratio change
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    loss       = 1'b0;
    if (ndiv_chg) begin
      state_d    = DISCARD;
      good_cnt_d = '0;
    end else if (win_wrap) begin
      case (state_q)
        DISCARD: state_d = ACQUIRE;
        ACQUIRE: begin
          if (!win_good) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == GW'(LOCK_WINDOWS - 1)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
        LOCKED: begin
          if (!win_good) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
            loss       = 1'b1;
          end
        end
        default: begin
          state_d    = DISCARD;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  // Sticky loss flag: a loss in the same cycle as a clear wins
  assign lock_lost_d = loss | (lock_lost_q & ~lk_if.clr_lost);

  // FSM and status registers
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= DISCARD;
      good_cnt_q  <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign lk_if.locked     = (state_q == LOCKED);
  assign lk_if.lock_lost  = lock_lost_q;
  assign lk_if.meas_count = meas_count_q;
  assign lk_if.meas_valid = meas_valid_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Scoreboard bench for pll_lock_detect with a shortened window so many windows fit in one run.
`timescale 1ns/1ps
module tb_pll_lock_detect;

  localparam int WIN_LOG2     = 9;
  localparam int DIV_LOG2     = 5;
  localparam int NW           = 8;
  localparam int TOL          = 2;
  localparam int LOCK_WINDOWS = 4;
  localparam int CW           = NW + WIN_LOG2 - DIV_LOG2 + 1;
  localparam int WLEN         = 1 << WIN_LOG2;
  localparam int SCALE        = 1 << (WIN_LOG2 - DIV_LOG2);
  localparam int CMAX         = (1 << CW) - 1;
  // A toggle sampled by the first sync flop at edge k is counted at edge k+2
  localparam int CNT_LAT      = 2;

  logic refclk = 1'b0;
  logic reset;

  pll_lock_detect_if #(.NW(NW), .CW(CW)) lk_if ();

  pll_lock_detect #(
    .WIN_LOG2     (WIN_LOG2),
    .DIV_LOG2     (DIV_LOG2),
    .NW           (NW),
    .TOL          (TOL),
    .LOCK_WINDOWS (LOCK_WINDOWS)
  ) dut (
    .refclk (refclk),
    .reset  (reset),
    .lk_if  (lk_if)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int count;
    bit locked;
    bit lost;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: lock decisions derived from per-window counts
  int m_n;
  bit m_discard;
  bit m_locked;
  bit m_lost;
  int m_run;

  int targets[$];
  int clr_at[$];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Window-level model: what a window holding cnt events does to lock status
  task automatic model_window(input int cnt, input bit clr);
    int  c;
    int  ex;
    bit  good;
    bit  lost_now;
    exp_t e;
    c        = (cnt > CMAX) ? CMAX : cnt;
    ex       = m_n * SCALE;
    good     = (c != CMAX) && (c - ex <= TOL) && (ex - c <= TOL);
    lost_now = 1'b0;
    if (m_discard) begin
      m_discard = 1'b0;
    end else if (good) begin
      if (!m_locked) begin
        m_run++;
        if (m_run >= LOCK_WINDOWS) begin
          m_locked = 1'b1;
          m_run    = 0;
        end
      end
    end else begin
      if (m_locked) lost_now = 1'b1;
      m_locked = 1'b0;
      m_run    = 0;
    end
    if (lost_now)  m_lost = 1'b1;
    else if (clr)  m_lost = 1'b0;
    e.count  = c;
    e.locked = m_locked;
    e.lost   = m_lost;
    exp_q.push_back(e);
  endtask

  function automatic int rand_target(input int n);
    int d;
    if ($urandom_range(0, 9) < 8) d = int'($urandom_range(0, 4)) - 2;
    else                          d = int'($urandom_range(0, 10)) - 5;
    if (n * SCALE + d < 0) return 0;
    return n * SCALE + d;
  endfunction

  task automatic fill_random(input int k, input int n);
    for (int w = 0; w < k; w++) begin
      targets.push_back(rand_target(n));
      if ($urandom_range(0, 9) < 3)
        clr_at.push_back(($urandom_range(0, 2) == 0) ? WLEN : int'($urandom_range(1, WLEN)));
      else
        clr_at.push_back(0);
    end
  endtask

  // Synchronous reset; the first reset edge must clear every output
  task automatic do_reset(input int n, input int cycles);
    check("pending_before_reset", exp_q.size(), 0);
    @(negedge refclk);
    reset          = 1'b1;
    lk_if.n_div    = NW'(n);
    lk_if.fb_tgl   = 1'b0;
    lk_if.clr_lost = 1'b0;
    @(posedge refclk);
    #1;
    check("rst_locked", lk_if.locked, 0);
    check("rst_lock_lost", lk_if.lock_lost, 0);
    check("rst_meas_count", lk_if.meas_count, 0);
    check("rst_meas_valid", lk_if.meas_valid, 0);
    repeat (cycles - 1) @(posedge refclk);
    m_n = n; m_discard = 1'b1; m_locked = 1'b0; m_lost = 1'b0; m_run = 0;
  endtask

  // Ratio change restarts acquisition without touching the sticky loss flag
  task automatic change_ndiv(input int n);
    check("pending_before_ndiv", exp_q.size(), 0);
    @(negedge refclk);
    lk_if.n_div = NW'(n);
    @(posedge refclk);
    #1;
    m_n = n; m_discard = 1'b1; m_locked = 1'b0; m_run = 0;
    check("ndiv_locked", lk_if.locked, 0);
    check("ndiv_lock_lost", lk_if.lock_lost, m_lost);
    check("ndiv_meas_valid", lk_if.meas_valid, 0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge refclk);
  endtask

  // Drive the windows in targets[]/clr_at[], starting right after the restart edge.
  // Toggles are placed by the edge at which they are counted, offset from the restart edge.
  task automatic run_windows();
    int ce_q[$];
    int k, t, base, span, e, j;
    bit clr_now;
    k = targets.size();
    for (int w = 0; w < k; w++) begin
      t = targets[w];
      if (w == 0) begin
        base = 8;
        span = WLEN - 16;
      end else begin
        base = w * WLEN + int'($urandom_range(0, 3));
        span = WLEN - 4;
      end
      for (int i = 0; i < t; i++) ce_q.push_back(base + (i * span) / t);
    end
    for (int m = 0; m <= k * WLEN; m++) begin
      @(negedge refclk);
      reset = 1'b0;
      if (ce_q.size() > 0 && ce_q[0] == m + 1 + CNT_LAT) begin
        void'(ce_q.pop_front());
        lk_if.fb_tgl = ~lk_if.fb_tgl;
      end
      e       = m + 1;
      j       = (e - 1) / WLEN;
      clr_now = (j < k) && (clr_at[j] > 0) && (e == j * WLEN + clr_at[j]);
      lk_if.clr_lost = clr_now;
      if (e % WLEN == 0) model_window(targets[j], clr_now);
      else if (clr_now)  m_lost = 1'b0;
      @(posedge refclk);
    end
    targets.delete();
    clr_at.delete();
  endtask

  // Monitor: every measurement pulse is matched against the oldest expected window
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge refclk);
      if (lk_if.meas_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("meas_valid_unexpected", lk_if.meas_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("meas_count", lk_if.meas_count, e.count);
          check("locked", lk_if.locked, e.locked);
          check("lock_lost", lk_if.lock_lost, e.lost);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    reset          = 1'b1;
    lk_if.n_div    = NW'(4);
    lk_if.fb_tgl   = 1'b0;
    lk_if.clr_lost = 1'b0;

    // Ideal lock, in/out of tolerance edges, loss, clear, relock, stuck toggle with coincident clear
    do_reset(4, 10);
    targets = {64, 64, 64, 64, 64, 66, 67, 62, 66, 64, 61, 64, 64, 64, 64, 0, 64, 64, 64, 64};
    for (int w = 0; w < targets.size(); w++) clr_at.push_back(0);
    clr_at[9]  = 200;
    clr_at[15] = WLEN;
    run_windows();

    // Ratio change while locked, reacquire at the new ratio, then random windows
    change_ndiv(5);
    for (int w = 0; w < 5; w++) begin
      targets.push_back(80);
      clr_at.push_back(0);
    end
    fill_random(15, 5);
    run_windows();

    // Zero ratio: only counts up to TOL are good
    idle(int'($urandom_range(1, 300)));
    change_ndiv(0);
    targets = {0, 2, 1, 0, 0, 3, 0, 0};
    for (int w = 0; w < targets.size(); w++) clr_at.push_back(0);
    run_windows();

    // Reset in the middle of a window, then random traffic
    idle(int'($urandom_range(1, 300)));
    n = int'($urandom_range(1, 6));
    do_reset(n, 3);
    fill_random(15, n);
    run_windows();

    // Random ratio change, random traffic
    idle(int'($urandom_range(1, 300)));
    n = m_n;
    while (n == m_n) n = int'($urandom_range(1, 6));
    change_ndiv(n);
    fill_random(10, n);
    run_windows();

    idle(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
